imem_loader: RTL and testbench

- Write side of the instruction memory. Accepts a framed byte stream (length header, then payload) over a valid/ready byte interface.
- Assembles payload bytes into little-endian 32-bit words, the same ordering the instruction fetch path reads back: first byte is bits [7:0].
- Issues one word write per 4 bytes to the instruction RAM, starting at address 0.
- Holds the CPU in stall (`cpu_hold`) while a load is in progress.

---
 rtl/imem_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_loader                                                   |
// | Purpose  : Write side of the instruction memory. Receives a framed byte  |
// |            stream (16-bit word count, little-endian, then payload),      |
// |            packs payload bytes little-endian into 32-bit words and       |
// |            writes them to the instruction RAM from address 0 upward,     |
// |            holding the CPU in stall while a load is in progress.         |
// | Option   : IMEM_LOADER_CHECKSUM_EN - a trailing XOR checksum byte        |
// |            follows the payload and must match for the load to succeed.   |
// | Ports    : clk, reset          - clock, synchronous active-high reset    |
// |            start               - one-cycle pulse, begins a load          |
// |            byte_valid/_data    - incoming byte stream                    |
// |            byte_ready          - loader can take a byte this cycle       |
// |            wr_en/addr/data     - instruction RAM word write port         |
// |            cpu_hold            - CPU stall request                       |
// |            done, error         - sticky load status                      |
// |            words_written       - words written in the current load       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_loader #(
   parameter int unsigned MEM_SIZE = 256,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;
`endif

   // Byte capacity in the same width as a byte count derived from a 16-bit
   // word count, so the length check cannot overflow.
   localparam logic [17:0] C_MEM_BYTES = 18'(MEM_SIZE);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [1:0]        k_q, k_d;
   logic [23:0]       shadow_q, shadow_d;    // bytes 0..2 of the word being assembled
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [15:0]       words_q, words_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   logic        w_xfer;
   logic [15:0] w_len_full;

   // byte_ready depends only on registered state, so it never loops back
   // through byte_valid.
   assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                       (state_q == ST_CHK) ||
`endif
                       (state_q == ST_DATA);
   assign w_xfer     = byte_valid && byte_ready;
   assign w_len_full = {byte_data, len_q[7:0]};

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      k_d       = k_q;
      shadow_d  = shadow_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      words_d   = words_q;
      done_d    = done_q;
      error_d   = error_q;
      hold_d    = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d     = chk_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN_LO;
               done_d  = 1'b0;
               error_d = 1'b0;
               words_d = 16'd0;
               k_d     = 2'd0;
               hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d   = 8'h00;
`endif
            end
         end

         ST_LEN_LO: begin
            if (w_xfer) begin
               len_d[7:0] = byte_data;
               state_d    = ST_LEN_HI;
            end
         end

         ST_LEN_HI: begin
            if (w_xfer) begin
               len_d[15:8] = byte_data;
               if ({w_len_full, 2'b00} > C_MEM_BYTES) begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
                  hold_d  = 1'b0;
               end else if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d = chk_q ^ byte_data;
`endif
               k_d = k_q + 2'd1;
               case (k_q)
                  2'd0:    shadow_d[7:0]   = byte_data;
                  2'd1:    shadow_d[15:8]  = byte_data;
                  2'd2:    shadow_d[23:16] = byte_data;
                  default: begin
                     // Word complete: the write issues next cycle from the
                     // output registers while the shadow refills freely.
                     wr_en_d   = 1'b1;
                     wr_addr_d = ADDR_W'({words_q, 2'b00});
                     wr_data_d = {byte_data, shadow_q};
                     words_d   = words_q + 16'd1;
                     if ((words_q + 16'd1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                     end
                  end
               endcase
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (w_xfer) begin
               hold_d = 1'b0;
               if (byte_data == chk_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
               end
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         len_q     <= 16'd0;
         k_q       <= 2'd0;
         shadow_q  <= 24'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 32'd0;
         words_q   <= 16'd0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         hold_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         k_q       <= k_d;
         shadow_q  <= shadow_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         words_q   <= words_d;
         done_q    <= done_d;
         error_q   <= error_d;
         hold_q    <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q     <= chk_d;
`endif
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign cpu_hold      = hold_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_written = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_loader                                                |
// | Purpose  : Scoreboard bench for imem_loader. Expected RAM writes are     |
// |            queued as frames are sent; a monitor pops and compares each   |
// |            wr_en pulse. Status outputs are checked after each load.      |
// |            Honours IMEM_LOADER_CHECKSUM_EN to match the DUT build.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   imem_loader #(.MEM_SIZE(256), .ADDR_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        hold;
   } wr_t;
   typedef logic [7:0] bq_t[$];

   wr_t sb[$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  n_wr = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: every write strobe must match the next queued expectation.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_t e;
         n_wr++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wr_unexpected: addr %h data %h with no write expected", wr_addr, wr_data);
         end else begin
            e = sb.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("hold_at_wr", {31'd0, cpu_hold}, {31'd0, e.hold});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         t++;
         if (t > 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_timeout: byte %h not accepted in 50 cycles", b);
            break;
         end
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic run_frame(input bq_t q, input int gap);
      foreach (q[i]) send(q[i], gap);
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      @(negedge clk);
      while (!(done || error) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_fail++;
         $display("FAIL end_timeout: done=%b error=%b after 50 cycles", done, error);
      end
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_wr_addr"}, wr_addr, 32'd0);
      check({tag, "_wr_data"}, wr_data, 32'd0);
      check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_words"}, {16'd0, words_written}, 32'd0);
   endtask

   // Two-word program from the bring-up image; checksum byte 0x1D appended
   // when the checksum build is active (93^02^60^FF^13 = 1D).
   task automatic two_word_load(input int gap, string tag);
      bq_t q;
      int  wr0;
      q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h60, 8'hFF, 8'h13, 8'h00, 8'h00, 8'h00};
      if (CHK_EN) q.push_back(8'h1D);
      sb.push_back('{32'h0, 32'hFF600293, 1'b1});
      sb.push_back('{32'h4, 32'h00000013, CHK_EN});
      wr0 = n_wr;
      do_start();
      check({tag, "_hold_start"}, {31'd0, cpu_hold}, 32'd1);
      run_frame(q, gap);
      wait_end();
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_words"}, {16'd0, words_written}, 32'd2);
      check({tag, "_hold_end"}, {31'd0, cpu_hold}, 32'd0);
      repeat (3) tick();
      check({tag, "_nwr"}, n_wr - wr0, 32'd2);
      check({tag, "_sb_empty"}, sb.size(), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Full-rate and throttled loads.
      two_word_load(0, "full");
      two_word_load(1, "gap");

      // 65 words = 260 bytes exceeds the 256-byte memory.
      wr0 = n_wr;
      do_start();
      send(8'h41, 0);
      send(8'h00, 0);
      wait_end();
      check("ovf_error", {31'd0, error}, 32'd1);
      check("ovf_done", {31'd0, done}, 32'd0);
      check("ovf_hold", {31'd0, cpu_hold}, 32'd0);
      repeat (3) tick();
      check("ovf_ready", {31'd0, byte_ready}, 32'd0);
      check("ovf_nwr", n_wr - wr0, 32'd0);

      // 64 words exactly fills memory: accepted, loader waits for payload.
      do_start();
      send(8'h40, 0);
      send(8'h00, 0);
      check("fit_ready", {31'd0, byte_ready}, 32'd1);
      check("fit_error", {31'd0, error}, 32'd0);
      check("fit_hold", {31'd0, cpu_hold}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("fit_rst");

      // Zero-length frame.
      wr0 = n_wr;
      do_start();
      send(8'h00, 0);
      send(8'h00, 0);
      if (CHK_EN) send(8'h00, 0);
      wait_end();
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_words", {16'd0, words_written}, 32'd0);
      check("zero_nwr", n_wr - wr0, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_start();
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'h01, 0);
      wait_end();
      check("zero_badchk_error", {31'd0, error}, 32'd1);
      check("zero_badchk_done", {31'd0, done}, 32'd0);

      // One word, good checksum 33^83^52^00 = E2.
      sb.push_back('{32'h0, 32'h00528333, 1'b1});
      do_start();
      run_frame('{8'h01, 8'h00, 8'h33, 8'h83, 8'h52, 8'h00, 8'hE2}, 0);
      wait_end();
      check("chk_ok_done", {31'd0, done}, 32'd1);
      check("chk_ok_words", {16'd0, words_written}, 32'd1);

      // Same word, wrong checksum: word still written, load fails.
      sb.push_back('{32'h0, 32'h00528333, 1'b1});
      do_start();
      run_frame('{8'h01, 8'h00, 8'h33, 8'h83, 8'h52, 8'h00, 8'hE3}, 0);
      wait_end();
      check("chk_bad_error", {31'd0, error}, 32'd1);
      check("chk_bad_done", {31'd0, done}, 32'd0);
      check("chk_bad_words", {16'd0, words_written}, 32'd1);
`endif

      // Reset after six bytes: first word is already on its way out.
      sb.push_back('{32'h0, 32'hFF600293, 1'b1});
      do_start();
      run_frame('{8'h02, 8'h00, 8'h93, 8'h02, 8'h60, 8'hFF}, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("midrst");
      check("midrst_sb_empty", sb.size(), 32'd0);
      two_word_load(0, "after_rst");

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
